// File: rtl/priority_decoder_driver.sv
// Sequential 2:4 decoder for {y, zero} priority-encoder codes. It takes codes through a
// valid/ready handshake, drives a one-hot line for HOLD_CYCLES, idles for GAP_CYCLES, then pulses done.
module priority_decoder_driver #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [1:0] y,
  input  logic       zero,
  output logic       ready,
  output logic [3:0] d,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned D_W   = 4;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [D_W-1:0]     d_next;
  logic               done_next;

  function automatic logic [D_W-1:0] onehot(input logic [IDX_W-1:0] i);
    return D_W'(1) << i;
  endfunction

  // Handshake status is decoded straight from the registered state
  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // State, counter, latched index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      d     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      d     <= d_next;
      done  <= done_next;
    end
  end

  // Next-state and output decode; the counter is reloaded only on state entry
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    d_next     = '0;
    done_next  = 1'b0;

    unique case (state)
      IDLE: begin
        if (valid) begin
          if (zero) begin
            done_next = 1'b1;
          end else begin
            idx_next   = y;
            cnt_next   = HOLD_LOAD;
            d_next     = onehot(y);
            state_next = DRIVE;
          end
        end
      end

      DRIVE: begin
        if (cnt == '0) begin
          if (HAS_GAP) begin
            cnt_next   = GAP_LOAD;
            state_next = GAP;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
          d_next   = onehot(idx);
        end
      end

      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_priority_decoder_driver.sv
// Bench for priority_decoder_driver. It runs three parameterisations side by side against a
// timeline model: each accepted code owns a window of hold, gap and done cycles counted from its accept edge.
module tb_priority_decoder_driver;

  localparam int N = 3;
  localparam int HOLD_A [N] = '{4, 1, 255};
  localparam int GAP_A  [N] = '{1, 0, 255};

  logic       clk;
  logic       rst_n;
  logic       valid_s [N];
  logic [1:0] y_s     [N];
  logic       zero_s  [N];
  logic       ready_s [N];
  logic [3:0] d_s     [N];
  logic       busy_s  [N];
  logic       done_s  [N];

  int pass_cnt;
  int total_cnt;

  // Model state: an active non-zero transaction and the edge that accepted it
  bit active  [N];
  int start_e [N];
  int idx_m   [N];
  int edge_n;

  priority_decoder_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_s[0]), .y(y_s[0]), .zero(zero_s[0]),
    .ready(ready_s[0]), .d(d_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  priority_decoder_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .valid(valid_s[1]), .y(y_s[1]), .zero(zero_s[1]),
    .ready(ready_s[1]), .d(d_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  priority_decoder_driver #(.HOLD_CYCLES(255), .GAP_CYCLES(255)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .valid(valid_s[2]), .y(y_s[2]), .zero(zero_s[2]),
    .ready(ready_s[2]), .d(d_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_all(input logic v, input logic [1:0] yy, input logic z);
    for (int i = 0; i < N; i++) begin
      valid_s[i] = v;
      y_s[i]     = yy;
      zero_s[i]  = z;
    end
  endtask

  // One clock: predict accepts, clock the DUTs, then compare the post-edge outputs
  task automatic step();
    bit acc  [N];
    bit accz [N];
    int yl   [N];
    for (int i = 0; i < N; i++) begin
      acc[i]  = valid_s[i] && !active[i] && !zero_s[i];
      accz[i] = valid_s[i] && !active[i] && zero_s[i];
      yl[i]   = int'(y_s[i]);
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int off;
      logic [3:0] exp_d;
      bit exp_busy;
      bit exp_done;
      exp_d    = 4'd0;
      exp_busy = 1'b0;
      exp_done = accz[i];
      if (acc[i]) begin
        active[i]  = 1'b1;
        start_e[i] = edge_n;
        idx_m[i]   = yl[i];
      end
      if (active[i]) begin
        off = edge_n - start_e[i];
        if (off < HOLD_A[i]) begin
          exp_d    = 4'(1 << idx_m[i]);
          exp_busy = 1'b1;
        end else if (off < HOLD_A[i] + GAP_A[i]) begin
          exp_busy = 1'b1;
        end else begin
          exp_done  = 1'b1;
          active[i] = 1'b0;
        end
      end
      check($sformatf("d[%0d]", i),     32'(d_s[i]),     32'(exp_d));
      check($sformatf("busy[%0d]", i),  32'(busy_s[i]),  32'(exp_busy));
      check($sformatf("ready[%0d]", i), 32'(ready_s[i]), 32'(!exp_busy));
      check($sformatf("done[%0d]", i),  32'(done_s[i]),  32'(exp_done));
    end
  endtask

  task automatic reset_check(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_d[%0d]", tag, i),     32'(d_s[i]),     32'd0);
      check($sformatf("%s_busy[%0d]", tag, i),  32'(busy_s[i]),  32'd0);
      check($sformatf("%s_ready[%0d]", tag, i), 32'(ready_s[i]), 32'd1);
      check($sformatf("%s_done[%0d]", tag, i),  32'(done_s[i]),  32'd0);
      active[i] = 1'b0;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    edge_n    = 0;
    for (int i = 0; i < N; i++) begin
      active[i]  = 1'b0;
      start_e[i] = 0;
      idx_m[i]   = 0;
    end
    drive_all(1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_check("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single non-zero code with y=2
    drive_all(1'b1, 2'd2, 1'b0);
    step();
    drive_all(1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 7; k++) step();

    // Back-to-back zero codes
    drive_all(1'b1, 2'd3, 1'b1);
    step();
    step();
    drive_all(1'b0, 2'd0, 1'b0);
    step();

    // Accept y=1, then toggle valid with y=3 while busy
    drive_all(1'b1, 2'd1, 1'b0);
    step();
    for (int k = 0; k < 12; k++) begin
      drive_all(k[0], 2'd3, 1'b0);
      step();
    end

    // Hold valid and walk y through 0..3
    for (int k = 0; k < 8; k++) begin
      drive_all(1'b1, 2'(k), 1'b0);
      step();
    end
    drive_all(1'b0, 2'd0, 1'b0);

    // Abandon an in-flight y=0 transaction with an asynchronous reset
    #2 rst_n = 1'b0;
    #1 reset_check("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    drive_all(1'b1, 2'd0, 1'b0);
    step();
    drive_all(1'b0, 2'd0, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1 reset_check("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Full-length transaction with y=3 (255 hold, 255 gap on the third instance)
    drive_all(1'b1, 2'd3, 1'b0);
    step();
    drive_all(1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 515; k++) step();

    // Randomized traffic, independent per instance
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        valid_s[i] = ($urandom_range(0, 9) < 6);
        y_s[i]     = 2'($urandom_range(0, 3));
        zero_s[i]  = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
